// File: rtl/turbo_pkg.sv
// turbo_pkg: shared LLR width, bank state encoding and permutation helper for the turbo loop
package turbo_pkg;
  localparam int EXT_W = 10;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;
  function automatic int pi_f(input int i, input int a, input int b, input int k);
    return (a * i + b) % k;
  endfunction
endpackage

// File: rtl/ext_interleaver_if.sv
// ext_interleaver_if: write (SISO output) and read (next SISO ext_i) streams of the extrinsic interleaver
interface ext_interleaver_if import turbo_pkg::*; #(parameter int DATA_W = EXT_W);
  logic              mode_i;
  logic              wr_valid_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_ready_o;
  logic              rd_ready_i;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_last_o;
  modport master(output mode_i, wr_valid_i, wr_data_i, rd_ready_i,
                 input wr_ready_o, rd_valid_o, rd_data_o, rd_last_o);
  modport slave(input mode_i, wr_valid_i, wr_data_i, rd_ready_i,
                output wr_ready_o, rd_valid_o, rd_data_o, rd_last_o);
endinterface

// File: rtl/intlv_addr_gen.sv
// intlv_addr_gen: incremental permutation address B, B+A, B+2A, ... wrapping mod 2^AW
module intlv_addr_gen import turbo_pkg::*; #(
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] start_i,
  input  logic [AW-1:0] step_i,
  input  logic          en_i,
  output logic [AW-1:0] addr_o
);
  logic [AW-1:0] addr_q, addr_d;
  // advance by the multiplier on each enabled step; K steps return to start, so no explicit block restart
  always_comb addr_d = en_i ? addr_q + step_i : addr_q;
  // address register, reloaded with the offset on reset
  always_ff @(posedge clk_i) addr_q <= rst_i ? start_i : addr_d;
  assign addr_o = addr_q;
endmodule

// File: rtl/ext_interleaver.sv
// ext_interleaver: ping-pong extrinsic interleave/deinterleave buffer; EXT_SCALE_EN enables x - (x>>>2) write scaling
module ext_interleaver import turbo_pkg::*; #(
  parameter int DATA_W    = EXT_W,
  parameter int BLOCK_LEN = 16,
  parameter int INTLV_A   = 5,
  parameter int INTLV_B   = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  ext_interleaver_if.slave bus
);
  localparam int AW = $clog2(BLOCK_LEN);
  localparam logic [AW-1:0] LAST = AW'(BLOCK_LEN - 1);
  localparam logic [AW-1:0] PA = AW'(INTLV_A);
  localparam logic [AW-1:0] PB = AW'(INTLV_B);
  bank_st_e st_q [2];
  bank_st_e st_d [2];
  logic [1:0] mode_q, mode_d;
  logic wb_q, wb_d, rb_q, rb_d;
  logic [AW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, wpi, rpi, waddr, raddr;
  logic [DATA_W-1:0] mem_q [2][BLOCK_LEN];
  logic [DATA_W-1:0] wdata;
  logic signed [DATA_W-1:0] wquarter;
  logic wr_en, rd_en, wmode;

  assign bus.wr_ready_o = st_q[wb_q] == EMPTY || st_q[wb_q] == FILLING;
  assign bus.rd_valid_o = st_q[rb_q] == FULL || st_q[rb_q] == DRAINING;
  assign wr_en = bus.wr_valid_i && bus.wr_ready_o;
  assign rd_en = bus.rd_valid_o && bus.rd_ready_i;
  assign wmode = st_q[wb_q] == EMPTY ? bus.mode_i : mode_q[wb_q];
  assign waddr = wmode ? wpi : wcnt_q;
  assign raddr = mode_q[rb_q] ? rcnt_q : rpi;
  assign bus.rd_data_o = bus.rd_valid_o ? mem_q[rb_q][raddr] : '0;
  assign bus.rd_last_o = bus.rd_valid_o && rcnt_q == LAST;
  assign wquarter = $signed(bus.wr_data_i) >>> 2;
`ifdef EXT_SCALE_EN
  assign wdata = bus.wr_data_i - wquarter;
`else
  assign wdata = bus.wr_data_i;
`endif

  intlv_addr_gen #(.AW(AW)) u_wr_gen (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(PB), .step_i(PA), .en_i(wr_en), .addr_o(wpi)
  );
  intlv_addr_gen #(.AW(AW)) u_rd_gen (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(PB), .step_i(PA), .en_i(rd_en), .addr_o(rpi)
  );

  // bank FSMs and pointers; write and read always target banks in disjoint states, so both updates can apply
  always_comb begin
    st_d   = st_q;
    mode_d = mode_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    if (wr_en) begin
      wcnt_d         = wcnt_q + 1'b1;
      mode_d[wb_q]   = wmode;
      st_d[wb_q]     = wcnt_q == LAST ? FULL : FILLING;
      wb_d           = wb_q ^ (wcnt_q == LAST);
    end
    if (rd_en) begin
      rcnt_d         = rcnt_q + 1'b1;
      st_d[rb_q]     = rcnt_q == LAST ? EMPTY : DRAINING;
      rb_d           = rb_q ^ (rcnt_q == LAST);
    end
  end

  // control state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= '{EMPTY, EMPTY};
      mode_q <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      mode_q <= mode_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  // sample storage, deliberately left uncleared by reset
  always_ff @(posedge clk_i) if (wr_en) mem_q[wb_q][waddr] <= wdata;
endmodule

// File: tb/tb_ext_interleaver.sv
// tb_ext_interleaver: scoreboard bench for ext_interleaver (K=16, A=5, B=3)
module tb_ext_interleaver;
  typedef logic [9:0] blk_t [16];
  typedef struct packed {logic [9:0] d; logic l;} exp_t;
  logic clk = 0, rst = 1, mon_en = 0;
  int checks = 0, fails = 0;
  exp_t q[$];
  exp_t e;
  blk_t v;
  always #5 clk = ~clk;
  ext_interleaver_if #(.DATA_W(10)) bus();
  ext_interleaver #(.DATA_W(10), .BLOCK_LEN(16), .INTLV_A(5), .INTLV_B(3)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  function automatic int pi(input int i);
    return (5 * i + 3) % 16;
  endfunction

  function automatic logic [9:0] sc(input logic [9:0] x);
`ifdef EXT_SCALE_EN
    logic signed [9:0] s;
    s = x;
    return s - (s >>> 2);
`else
    return x;
`endif
  endfunction

  task automatic push_block(input blk_t b, input logic m);
    blk_t o;
    for (int i = 0; i < 16; i++) if (m) o[pi(i)] = b[i]; else o[i] = b[pi(i)];
    for (int j = 0; j < 16; j++) q.push_back('{d: sc(o[j]), l: (j == 15)});
  endtask

  task automatic write_block(input blk_t b, input logic m, input bit rise);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus.wr_valid_i = 1; bus.wr_data_i = b[i]; bus.mode_i = m;
      chk("wr_ready_on_write", bus.wr_ready_o, 1);
      if (rise && i == 15) chk("rv_before_last_write", bus.rd_valid_o, 0);
    end
    @(posedge clk); #1;
    bus.wr_valid_i = 0;
    if (rise) chk("rv_after_last_write", bus.rd_valid_o, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.rd_valid_o && bus.rd_ready_i) begin
        chk("q_avail", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rd_data", bus.rd_data_o, e.d);
          chk("rd_last", bus.rd_last_o, e.l);
        end
      end else if (!bus.rd_valid_o) chk("rd_last_idle", bus.rd_last_o, 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    bus.mode_i = 0; bus.wr_valid_i = 0; bus.wr_data_i = 0; bus.rd_ready_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0; mon_en = 1;
    chk("rst_wr_ready", bus.wr_ready_o, 1);
    chk("rst_rd_valid", bus.rd_valid_o, 0);
    chk("rst_rd_data", bus.rd_data_o, 0);
    chk("rst_rd_last", bus.rd_last_o, 0);
    bus.rd_ready_i = 1;
    for (int i = 0; i < 16; i++) v[i] = 10'(i);
    push_block(v, 0); write_block(v, 0, 1); drain();
    for (int i = 0; i < 16; i++) v[i] = 10'(pi(i));
    push_block(v, 1); write_block(v, 1, 0); drain();
    bus.rd_ready_i = 0;
    for (int i = 0; i < 16; i++) v[i] = 10'(100 + i);
    push_block(v, 0); write_block(v, 0, 0);
    for (int i = 0; i < 16; i++) v[i] = 10'(200 + i);
    push_block(v, 0); write_block(v, 0, 0);
    chk("wr_ready_both_full", bus.wr_ready_o, 0);
    bus.rd_ready_i = 1;
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge clk); #1;
      if (bus.rd_valid_o && bus.rd_last_o) begin
        found = 1;
        chk("wr_ready_at_last_read", bus.wr_ready_o, 0);
        @(posedge clk); #1;
        chk("wr_ready_after_last_read", bus.wr_ready_o, 1);
      end
    end
    chk("found_last", found, 1);
    for (int i = 0; i < 16; i++) v[i] = 10'(300 + i);
    push_block(v, 0); write_block(v, 0, 0); drain();
    for (int i = 0; i < 16; i++) v[i] = 10'(i);
    push_block(v, 0); write_block(v, 0, 0);
    repeat (5) begin @(posedge clk); #1; end
    bus.rd_ready_i = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_data", bus.rd_data_o, sc(10'd12));
      chk("bp_valid", bus.rd_valid_o, 1);
      chk("bp_last", bus.rd_last_o, 0);
    end
    bus.rd_ready_i = 1;
    drain();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      bus.wr_valid_i = 1; bus.wr_data_i = 10'(i); bus.mode_i = 0;
    end
    @(posedge clk); #1;
    bus.wr_valid_i = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_wr_ready", bus.wr_ready_o, 1);
    chk("midrst_rd_valid", bus.rd_valid_o, 0);
    for (int i = 0; i < 16; i++) v[i] = 10'(50 + i);
    push_block(v, 0); write_block(v, 0, 0); drain();
    for (int i = 0; i < 16; i++) v[i] = 10'(0);
    v[0] = 10'h200; v[1] = 10'h3FF; v[2] = 10'h1FF; v[3] = 10'd4;
    push_block(v, 0); write_block(v, 0, 0); drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
